// File: rtl/vtg_pkg.sv
// Shared types and colour constants for the video timing generator and its pattern source.
package vtg_pkg;

    typedef enum logic [1:0] {
        VTG_BARS  = 2'd0,
        VTG_GRID  = 2'd1,
        VTG_GRAD  = 2'd2,
        VTG_SOLID = 2'd3
    } vtg_mode_e;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return COL_WHITE;
            3'd1:    return COL_YELLOW;
            3'd2:    return COL_CYAN;
            3'd3:    return COL_GREEN;
            3'd4:    return COL_MAGENTA;
            3'd5:    return COL_RED;
            3'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vtg_pattern.sv
// Combinational test-pattern source: maps raster position, latched mode and frame count to RGB.
module vtg_pattern
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int CNT_W     = 12,
    parameter int GRID_LOG2 = 5
) (
    input  logic [CNT_W-1:0] h,
    input  logic [CNT_W-1:0] v,
    input  vtg_mode_e        mode,
    input  logic [23:0]      solid_rgb,
    input  logic [7:0]       frame_cnt,
    output logic [23:0]      rgb
);

    localparam int BAR_W_RAW = H_ACTIVE / 8;
    localparam int BAR_W     = (BAR_W_RAW > 0) ? BAR_W_RAW : 1;
    localparam logic [CNT_W-1:0] BAR_W_C    = CNT_W'(BAR_W);
    localparam logic [CNT_W-1:0] BAR_MAX_C  = CNT_W'(7);
    localparam logic [CNT_W-1:0] H_LAST_ACT = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST_ACT = CNT_W'(V_ACTIVE - 1);

    logic [CNT_W-1:0] bar_idx;
    logic [2:0]       bar_sel;
    logic             grid_on;

    always_comb begin
        bar_idx = h / BAR_W_C;
        // Remainder pixels past the eighth bar fold into the last (black) bar.
        bar_sel = (bar_idx > BAR_MAX_C) ? 3'd7 : bar_idx[2:0];
        grid_on = (h[GRID_LOG2-1:0] == '0) || (v[GRID_LOG2-1:0] == '0) ||
                  (h == H_LAST_ACT) || (v == V_LAST_ACT);
        rgb     = '0;
        case (mode)
            VTG_BARS:  rgb = bar_color(bar_sel);
            VTG_GRID:  rgb = grid_on ? COL_WHITE : COL_BLACK;
            VTG_GRAD:  rgb = {h[7:0], v[7:0], frame_cnt};
            VTG_SOLID: rgb = solid_rgb;
            default:   rgb = '0;
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with registered syncs, flags, coordinates and RGB.
// Define VTG_PATTERN_EN to build the test-pattern source; otherwise RGB is held at zero.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   CNT_W     = 12,
    parameter int   GRID_LOG2 = 5
) (
    input  logic             pixel_clock,
    input  logic             reset,
    input  logic [1:0]       pattern_mode,
    input  logic [23:0]      solid_rgb,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic [7:0]       VGA_R,
    output logic [7:0]       VGA_G,
    output logic [7:0]       VGA_B,
    output logic             VGA_DE,
    output logic             VGA_HBLANK,
    output logic             VGA_VBLANK,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             h_wrap;
    logic             frame_wrap;
    logic             hblank_c;
    logic             vblank_c;
    logic             de_c;
    logic             hs_c;
    logic             vs_c;
    logic             fs_c;
    logic [23:0]      rgb_c;

    assign h_wrap     = (h == H_LAST);
    assign frame_wrap = h_wrap && (v == V_LAST);
    assign hblank_c   = (h >= H_ACT_C);
    assign vblank_c   = (v >= V_ACT_C);
    assign de_c       = !hblank_c && !vblank_c;
    assign hs_c       = ((h >= HS_START) && (h < HS_END)) ? HS_POL : ~HS_POL;
    assign vs_c       = ((v >= VS_START) && (v < VS_END)) ? VS_POL : ~VS_POL;
    assign fs_c       = (h == '0) && (v == '0);

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            h         <= '0;
            v         <= '0;
            frame_cnt <= '0;
        end else begin
            h <= h_wrap ? '0 : h + 1'b1;
            if (h_wrap) begin
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

`ifdef VTG_PATTERN_EN
    vtg_mode_e   mode_q;
    logic [23:0] solid_q;
    logic [23:0] pat_rgb;

    // Pattern settings only change at the frame wrap so a frame is never torn.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            mode_q  <= VTG_BARS;
            solid_q <= '0;
        end else if (frame_wrap) begin
            mode_q  <= vtg_mode_e'(pattern_mode);
            solid_q <= solid_rgb;
        end
    end

    vtg_pattern #(
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .CNT_W     (CNT_W),
        .GRID_LOG2 (GRID_LOG2)
    ) u_pattern (
        .h         (h),
        .v         (v),
        .mode      (mode_q),
        .solid_rgb (solid_q),
        .frame_cnt (frame_cnt),
        .rgb       (pat_rgb)
    );

    assign rgb_c = de_c ? pat_rgb : 24'h0;
`else
    logic unused_pattern_inputs;
    assign unused_pattern_inputs = ^{pattern_mode, solid_rgb};
    assign rgb_c = 24'h0;
`endif

    // Output stage: everything derived from (h, v) is registered together.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            hcnt                  <= '0;
            vcnt                  <= '0;
            VGA_HS                <= ~HS_POL;
            VGA_VS                <= ~VS_POL;
            VGA_HBLANK            <= 1'b1;
            VGA_VBLANK            <= 1'b1;
            VGA_DE                <= 1'b0;
            frame_start           <= 1'b0;
            {VGA_R, VGA_G, VGA_B} <= '0;
        end else begin
            hcnt                  <= h;
            vcnt                  <= v;
            VGA_HS                <= hs_c;
            VGA_VS                <= vs_c;
            VGA_HBLANK            <= hblank_c;
            VGA_VBLANK            <= vblank_c;
            VGA_DE                <= de_c;
            frame_start           <= fs_c;
            {VGA_R, VGA_G, VGA_B} <= rgb_c;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 instance for line timing, small 16x8 instance for frame behaviour.
module tb_video_timing_gen;

    logic        pixel_clock = 1'b0;
    always #5 pixel_clock = ~pixel_clock;

    int vectors     = 0;
    int miscompares = 0;
    int pix_b       = -1;

    // Default-mode instance
    logic        reset_a;
    logic [1:0]  mode_a;
    logic [23:0] solid_a;
    logic [11:0] hcnt_a, vcnt_a;
    logic        hs_a, vs_a, de_a, hb_a, vb_a, fs_a;
    logic [7:0]  r_a, g_a, b_a, fc_a;

    // Small-raster instance: H_TOTAL=20 (sync 17..18), V_TOTAL=11 (sync line 9), 220 cycles/frame
    logic        reset_b;
    logic [1:0]  mode_b;
    logic [23:0] solid_b;
    logic [11:0] hcnt_b, vcnt_b;
    logic        hs_b, vs_b, de_b, hb_b, vb_b, fs_b;
    logic [7:0]  r_b, g_b, b_b, fc_b;

    video_timing_gen u_dut_a (
        .pixel_clock (pixel_clock),
        .reset       (reset_a),
        .pattern_mode(mode_a),
        .solid_rgb   (solid_a),
        .hcnt        (hcnt_a),
        .vcnt        (vcnt_a),
        .VGA_HS      (hs_a),
        .VGA_VS      (vs_a),
        .VGA_R       (r_a),
        .VGA_G       (g_a),
        .VGA_B       (b_a),
        .VGA_DE      (de_a),
        .VGA_HBLANK  (hb_a),
        .VGA_VBLANK  (vb_a),
        .frame_start (fs_a),
        .frame_cnt   (fc_a)
    );

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(1), .V_BP(1),
        .GRID_LOG2(2)
    ) u_dut_b (
        .pixel_clock (pixel_clock),
        .reset       (reset_b),
        .pattern_mode(mode_b),
        .solid_rgb   (solid_b),
        .hcnt        (hcnt_b),
        .vcnt        (vcnt_b),
        .VGA_HS      (hs_b),
        .VGA_VS      (vs_b),
        .VGA_R       (r_b),
        .VGA_G       (g_b),
        .VGA_B       (b_b),
        .VGA_DE      (de_b),
        .VGA_HBLANK  (hb_b),
        .VGA_VBLANK  (vb_b),
        .frame_start (fs_b),
        .frame_cnt   (fc_b)
    );

    function automatic logic [31:0] ec(input logic [23:0] c);
`ifdef VTG_PATTERN_EN
        return 32'(c);
`else
        return 32'(c & 24'h0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto_b(input int target);
        while (pix_b < target) begin
            @(posedge pixel_clock);
            #1;
            pix_b++;
        end
    endtask

    task automatic chk_reset_b(input string tag);
        chk({tag, "_hcnt"},  32'(hcnt_b), 32'd0);
        chk({tag, "_vcnt"},  32'(vcnt_b), 32'd0);
        chk({tag, "_hs"},    32'(hs_b),   32'd1);
        chk({tag, "_vs"},    32'(vs_b),   32'd1);
        chk({tag, "_hb"},    32'(hb_b),   32'd1);
        chk({tag, "_vb"},    32'(vb_b),   32'd1);
        chk({tag, "_de"},    32'(de_b),   32'd0);
        chk({tag, "_rgb"},   32'({r_b, g_b, b_b}), 32'd0);
        chk({tag, "_fs"},    32'(fs_b),   32'd0);
        chk({tag, "_fcnt"},  32'(fc_b),   32'd0);
    endtask

    initial begin
        int hs_low_cnt = 0;
        int hb_cnt     = 0;
        int hs_first   = -1;

        reset_a = 1'b1; reset_b = 1'b1;
        mode_a  = 2'd0; solid_a = 24'h0;
        mode_b  = 2'd0; solid_b = 24'h0;
        repeat (3) @(posedge pixel_clock);
        #1;

        // Reset values held while reset is high
        chk("rst_a_hcnt", 32'(hcnt_a), 32'd0);
        chk("rst_a_vcnt", 32'(vcnt_a), 32'd0);
        chk("rst_a_hs",   32'(hs_a),   32'd1);
        chk("rst_a_vs",   32'(vs_a),   32'd1);
        chk("rst_a_hb",   32'(hb_a),   32'd1);
        chk("rst_a_vb",   32'(vb_a),   32'd1);
        chk("rst_a_de",   32'(de_a),   32'd0);
        chk("rst_a_rgb",  32'({r_a, g_a, b_a}), 32'd0);
        chk("rst_a_fs",   32'(fs_a),   32'd0);
        chk("rst_a_fcnt", 32'(fc_a),   32'd0);
        chk_reset_b("rst_b");

        // One full 800-cycle line on the default-mode instance
        @(negedge pixel_clock);
        reset_a = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(posedge pixel_clock);
            #1;
            if (hs_a == 1'b0) begin
                if (hs_first < 0) hs_first = int'(hcnt_a);
                hs_low_cnt++;
            end
            if (hb_a) hb_cnt++;
            if (i == 0) begin
                chk("a_first_hcnt", 32'(hcnt_a), 32'd0);
                chk("a_first_vcnt", 32'(vcnt_a), 32'd0);
                chk("a_first_de",   32'(de_a),   32'd1);
                chk("a_first_fs",   32'(fs_a),   32'd1);
                chk("a_first_rgb",  32'({r_a, g_a, b_a}), ec(24'hFFFFFF));
            end
            if (i == 1)   chk("a_fs_drop",   32'(fs_a), 32'd0);
            if (i == 79)  chk("a_bar_h79",   32'({r_a, g_a, b_a}), ec(24'hFFFFFF));
            if (i == 80)  chk("a_bar_h80",   32'({r_a, g_a, b_a}), ec(24'hFFFF00));
            if (i == 639) chk("a_bar_h639",  32'({r_a, g_a, b_a}), ec(24'h000000));
            if (i == 640) begin
                chk("a_h640_rgb", 32'({r_a, g_a, b_a}), 32'd0);
                chk("a_h640_de",  32'(de_a), 32'd0);
                chk("a_h640_hcnt", 32'(hcnt_a), 32'd640);
            end
        end
        chk("a_hs_first",  32'(hs_first),   32'd656);
        chk("a_hs_width",  32'(hs_low_cnt), 32'd96);
        chk("a_hblank_len", 32'(hb_cnt),    32'd160);
        @(posedge pixel_clock);
        #1;
        chk("a_line_wrap_hcnt", 32'(hcnt_a), 32'd0);
        chk("a_line_wrap_vcnt", 32'(vcnt_a), 32'd1);
        reset_a = 1'b1;

        // Small raster: bars, blanking, syncs
        @(negedge pixel_clock);
        reset_b = 1'b0;
        pix_b   = -1;
        goto_b(0);
        chk("b_first_hcnt", 32'(hcnt_b), 32'd0);
        chk("b_first_fs",   32'(fs_b),   32'd1);
        chk("b_first_de",   32'(de_b),   32'd1);
        chk("b_first_rgb",  32'({r_b, g_b, b_b}), ec(24'hFFFFFF));
        goto_b(2);
        chk("b_bar1", 32'({r_b, g_b, b_b}), ec(24'hFFFF00));
        goto_b(4);
        chk("b_bar2", 32'({r_b, g_b, b_b}), ec(24'h00FFFF));
        goto_b(16);
        chk("b_h16_hb",  32'(hb_b), 32'd1);
        chk("b_h16_rgb", 32'({r_b, g_b, b_b}), 32'd0);
        chk("b_h16_hs",  32'(hs_b), 32'd1);
        goto_b(17);
        chk("b_h17_hs",  32'(hs_b), 32'd0);
        goto_b(18);
        chk("b_h18_hs",  32'(hs_b), 32'd0);
        goto_b(19);
        chk("b_h19_hs",  32'(hs_b), 32'd1);

        // Mode change mid-frame must not show until the next frame
        goto_b(100);
        mode_b  = 2'd3;
        solid_b = 24'h123456;
        goto_b(120);
        chk("b_v6_vcnt", 32'(vcnt_b), 32'd6);
        chk("b_v6_still_bars", 32'({r_b, g_b, b_b}), ec(24'hFFFFFF));
        goto_b(160);
        chk("b_v8_vb", 32'(vb_b), 32'd1);
        chk("b_v8_vs", 32'(vs_b), 32'd1);
        chk("b_v8_de", 32'(de_b), 32'd0);
        goto_b(180);
        chk("b_v9_vs", 32'(vs_b), 32'd0);
        goto_b(200);
        chk("b_v10_vs", 32'(vs_b), 32'd1);
        goto_b(218);
        chk("b_f0_fcnt", 32'(fc_b), 32'd0);
        goto_b(220);
        chk("b_f1_hcnt",  32'(hcnt_b), 32'd0);
        chk("b_f1_vcnt",  32'(vcnt_b), 32'd0);
        chk("b_f1_fs",    32'(fs_b),   32'd1);
        chk("b_f1_fcnt",  32'(fc_b),   32'd1);
        chk("b_f1_solid", 32'({r_b, g_b, b_b}), ec(24'h123456));
        goto_b(221);
        chk("b_f1_fs_drop", 32'(fs_b), 32'd0);
        mode_b = 2'd1;

        // Grid frame (pitch 4, borders at h=15 and v=7)
        goto_b(440);
        chk("b_f2_fs",   32'(fs_b), 32'd1);
        chk("b_grid_0_0", 32'({r_b, g_b, b_b}), ec(24'hFFFFFF));
        goto_b(440 + 1 * 20 + 1);
        chk("b_grid_1_1", 32'({r_b, g_b, b_b}), ec(24'h000000));
        goto_b(440 + 1 * 20 + 4);
        chk("b_grid_4_1", 32'({r_b, g_b, b_b}), ec(24'hFFFFFF));
        goto_b(440 + 1 * 20 + 15);
        chk("b_grid_15_1", 32'({r_b, g_b, b_b}), ec(24'hFFFFFF));
        goto_b(440 + 3 * 20 + 2);
        chk("b_grid_2_3", 32'({r_b, g_b, b_b}), ec(24'h000000));
        goto_b(440 + 4 * 20 + 1);
        chk("b_grid_1_4", 32'({r_b, g_b, b_b}), ec(24'hFFFFFF));
        goto_b(440 + 7 * 20 + 1);
        chk("b_grid_1_7", 32'({r_b, g_b, b_b}), ec(24'hFFFFFF));
        goto_b(600);
        mode_b = 2'd2;

        // Gradient frame 3: R=h, G=v, B=frame_cnt
        goto_b(660 + 2 * 20 + 5);
        chk("b_grad_5_2", 32'({r_b, g_b, b_b}), ec(24'h050203));

        // Frame counter wrap
        goto_b(255 * 220);
        chk("b_f255_fcnt", 32'(fc_b), 32'd255);
        chk("b_f255_fs",   32'(fs_b), 32'd1);
        goto_b(256 * 220);
        chk("b_f256_fcnt", 32'(fc_b), 32'd0);
        chk("b_f256_fs",   32'(fs_b), 32'd1);

        // Asynchronous reset mid-frame, held three cycles
        goto_b(256 * 220 + 3 * 20 + 5);
        chk("b_pre_rst_hcnt", 32'(hcnt_b), 32'd5);
        chk("b_pre_rst_vcnt", 32'(vcnt_b), 32'd3);
        @(negedge pixel_clock);
        reset_b = 1'b1;
        #1;
        chk_reset_b("midrst_now");
        repeat (3) @(posedge pixel_clock);
        #1;
        chk_reset_b("midrst_held");
        @(negedge pixel_clock);
        reset_b = 1'b0;
        pix_b   = -1;
        goto_b(0);
        chk("b_restart_hcnt", 32'(hcnt_b), 32'd0);
        chk("b_restart_vcnt", 32'(vcnt_b), 32'd0);
        chk("b_restart_fs",   32'(fs_b),   32'd1);
        chk("b_restart_fcnt", 32'(fc_b),   32'd0);
        chk("b_restart_de",   32'(de_b),   32'd1);
        chk("b_restart_bars", 32'({r_b, g_b, b_b}), ec(24'hFFFFFF));
        goto_b(2);
        chk("b_restart_bar1", 32'({r_b, g_b, b_b}), ec(24'hFFFF00));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
